// File: rtl/adc_spi_pkg.sv
// ADC SPI sampler shared types and default constants.
// Latency: n/a (package only).
// Backpressure: n/a; holds the FSM state enum, default sizing and a small max helper.
package adc_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        QUIET
    } state_t;

    localparam int ADC_DATA_W     = 12;
    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_CLK_DIV    = 4;
    localparam int ADC_CS_SETUP   = 2;
    localparam int ADC_CS_QUIET   = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adc_spi_sampler_if.sv
// Bundle of the sampler's pin-level SPI signals and its sample output.
// Latency: n/a (wiring only).
// Backpressure: none; sample_valid is a one-cycle strobe the consumer must take.
// Ports: start/miso (async pins into the sampler), cs_n/sck (SPI master outputs),
//        busy, sample_valid, sample_data (towards the threshold stage).
interface adc_spi_sampler_if #(
    parameter int DATA_W = adc_spi_pkg::ADC_DATA_W
);
    logic              start;
    logic              miso;
    logic              cs_n;
    logic              sck;
    logic              busy;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;

    // master: the sampler itself
    modport master (
        input  start, miso,
        output cs_n, sck, busy, sample_valid, sample_data
    );

    // slave: ADC pins plus the downstream consumer
    modport slave (
        output start, miso,
        input  cs_n, sck, busy, sample_valid, sample_data
    );
endinterface

// File: rtl/adc_spi_sampler_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin.
// Latency: 2 clk from pin change to q.
// Backpressure: none. Ports: clk, rst_n (sync, active low), d (async in), q (synced out).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/adc_spi_sampler.sv
// SPI master reading one ADC frame per request; presents the last DATA_W bits MSB-first.
// Latency: cs_n low 3 clk after start pin; sample_valid CS_SETUP+2*CLK_DIV*FRAME_BITS clk after cs_n falls.
// Backpressure: none; sample_valid is a 1-cycle strobe, sample_data holds until the next one.
// Ports: clk, rst_n (sync, active low), bus (adc_spi_sampler_if.master).
// Build option ADC_AVG4_EN: output the truncated mean of every 4 frames instead of each frame.
module adc_spi_sampler
    import adc_spi_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int FRAME_BITS = ADC_FRAME_BITS,
    parameter int CLK_DIV    = ADC_CLK_DIV,
    parameter int CS_SETUP   = ADC_CS_SETUP,
    parameter int CS_QUIET   = ADC_CS_QUIET
) (
    input  logic                clk,
    input  logic                rst_n,
    adc_spi_sampler_if.master   bus
);
    localparam int CNT_W = $clog2(max3(CLK_DIV, CS_SETUP, CS_QUIET));
    localparam int BIT_W = $clog2(FRAME_BITS + 1);

    logic start_s, miso_s;

    sync_2ff u_sync_start (.clk(clk), .rst_n(rst_n), .d(bus.start), .q(start_s));
    sync_2ff u_sync_miso  (.clk(clk), .rst_n(rst_n), .d(bus.miso),  .q(miso_s));

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, shreg_nxt;
    logic              cs_n_q, cs_n_d;
    logic              sck_q, sck_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
`ifdef ADC_AVG4_EN
    logic [DATA_W+1:0] acc_q, acc_d, acc_sum;
    logic [1:0]        frm_q, frm_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        // Leading frame bits simply fall off the top of the register.
        shreg_nxt = {shreg_q[DATA_W-2:0], miso_s};
`ifdef ADC_AVG4_EN
        acc_d     = acc_q;
        frm_d     = frm_q;
        acc_sum   = acc_q + {2'b00, shreg_nxt};
`endif
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        // Last clk of the high phase: the ADC bit has been stable
                        // since the previous falling edge, well past the sync delay.
                        sck_d   = 1'b0;
                        shreg_d = shreg_nxt;
                        bit_d   = bit_q + BIT_W'(1);
                        if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                            state_d = QUIET;
                            cs_n_d  = 1'b1;
                            bit_d   = '0;
`ifdef ADC_AVG4_EN
                            if (frm_q == 2'd3) begin
                                valid_d = 1'b1;
                                data_d  = acc_sum[DATA_W+1:2];
                                acc_d   = '0;
                                frm_d   = '0;
                            end else begin
                                acc_d = acc_sum;
                                frm_d = frm_q + 2'd1;
                            end
`else
                            valid_d = 1'b1;
                            data_d  = shreg_nxt;
`endif
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            QUIET: begin
                // The single IDLE cycle that follows is the last quiet cycle, so
                // back-to-back frames see cs_n high for exactly CS_QUIET clocks.
                if (cnt_q == CNT_W'(CS_QUIET - 2)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
`ifdef ADC_AVG4_EN
            acc_q   <= '0;
            frm_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
`ifdef ADC_AVG4_EN
            acc_q   <= acc_d;
            frm_q   <= frm_d;
`endif
        end
    end

    assign bus.cs_n         = cs_n_q;
    assign bus.sck          = sck_q;
    assign bus.busy         = busy_q;
    assign bus.sample_valid = valid_q;
    assign bus.sample_data  = data_q;
endmodule

// File: tb/tb_adc_spi_sampler.sv
// Testbench for adc_spi_sampler: ADC pin model, event monitor and frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_adc_spi_sampler;
    import adc_spi_pkg::*;

    localparam int DW  = 12;
    localparam int FB  = 16;
    localparam int CD  = 4;
    localparam int CSS = 2;
    localparam int CSQ = 4;
    localparam int LAT = CSS + 2 * CD * FB;   // cs_n fall to sample_valid: 130

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adc_spi_sampler_if #(.DATA_W(DW)) bus ();

    adc_spi_sampler #(
        .DATA_W(DW), .FRAME_BITS(FB), .CLK_DIV(CD), .CS_SETUP(CSS), .CS_QUIET(CSQ)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // ---------------- monitor + ADC pin model (negedge, away from the active edge)
    int cyc = 0;
    logic p_cs = 1'b1, p_sck = 1'b0;
    int run = 0, rises = 0, bad_runs = 0;
    bit first_low = 0;
    int cs_fall_q[$], cs_rise_q[$], val_cyc_q[$];
    logic [DW-1:0] val_dat_q[$];
    logic [15:0] adc_words[$];
    logic [15:0] cur_word = 16'h0;
    int idx = FB, low_age = 0;
    bit glitch_en = 0;

    always @(negedge clk) begin
        logic b;
        cyc++;
        if (!p_cs) begin
            if (bus.sck !== p_sck) begin
                if (p_sck) begin
                    if (run != CD) bad_runs++;
                end else begin
                    if (run != (first_low ? CSS + CD : CD)) bad_runs++;
                    rises++;
                    first_low = 0;
                end
                run = 1;
            end else begin
                run++;
            end
        end
        if (p_cs && !bus.cs_n) begin
            cs_fall_q.push_back(cyc);
            run = 1; first_low = 1; idx = 0; low_age = 0;
            if (adc_words.size() > 0) cur_word = adc_words.pop_front();
        end else if (!bus.cs_n && p_sck && !bus.sck) begin
            idx++; low_age = 0;   // ADC shifts out the next bit on sck fall
        end else begin
            low_age++;
        end
        if (!p_cs && bus.cs_n) cs_rise_q.push_back(cyc);
        if (bus.sample_valid) begin
            val_cyc_q.push_back(cyc);
            val_dat_q.push_back(bus.sample_data);
        end
        b = (idx < FB) ? cur_word[FB-1-idx] : 1'b0;
        // Glitches only early in a low phase, far from the sampling point.
        if (glitch_en && !bus.cs_n && !bus.sck && low_age < 3 && $urandom_range(0, 1) == 1)
            b = ~b;
        bus.miso = b;
        p_cs = bus.cs_n;
        p_sck = bus.sck;
    end

    // ---------------- reference model: frame word -> expected strobes
    logic [DW-1:0] exp_q[$];
    int grp_n = 0, grp_sum = 0;

    task automatic model_frame(input logic [15:0] w);
        int s;
        s = int'(w) % (1 << DW);   // last DW bits of the frame
`ifdef ADC_AVG4_EN
        grp_sum += s;
        grp_n++;
        if (grp_n == 4) begin
            exp_q.push_back(DW'(grp_sum / 4));
            grp_sum = 0;
            grp_n = 0;
        end
`else
        exp_q.push_back(DW'(s));
`endif
    endtask

    task automatic model_reset();
        grp_sum = 0;
        grp_n = 0;
        exp_q.delete();
    endtask

    // ---------------- helpers
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] w);
        adc_words.push_back(w);
        model_frame(w);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int tgt_rise);
        int n;
        n = 0;
        while (!(cs_rise_q.size() >= tgt_rise && bus.busy == 1'b0) && n < 600) begin
            tick(1);
            n++;
        end
        check({nm, " done"}, 32'(n < 600), 32'd1);
    endtask

    function automatic int last_fall(input int vc);
        int r;
        r = -1000;
        foreach (cs_fall_q[k]) if (cs_fall_q[k] <= vc) r = cs_fall_q[k];
        return r;
    endfunction

    task automatic score(input string nm, input int r0, input int b0, input int exp_rises);
        int vc;
        logic [DW-1:0] vd;
        while (val_cyc_q.size() > 0) begin
            vc = val_cyc_q.pop_front();
            vd = val_dat_q.pop_front();
            check({nm, " valid_lat"}, 32'(vc - last_fall(vc)), 32'(LAT));
            if (exp_q.size() > 0) check({nm, " data"}, 32'(vd), 32'(exp_q.pop_front()));
            else check({nm, " extra_valid"}, 32'd1, 32'd0);
        end
        check({nm, " missing_valid"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check({nm, " sck_pulses"}, 32'(rises - r0), 32'(exp_rises));
        check({nm, " sck_phases"}, 32'(bad_runs - b0), 32'd0);
        check({nm, " cs_low_len"}, 32'(cs_rise_q[$] - cs_fall_q[$]), 32'(LAT));
    endtask

    typedef struct {
        logic [15:0]   word;
        logic [DW-1:0] raw;
    } vec_t;
    vec_t tbl[6];
    logic [15:0] avg_w[4];

    initial begin
        int r0, b0, s, d, f0, n, off;
        logic [15:0] w;
        tbl[0] = '{16'h0ABC, 12'hABC};
        tbl[1] = '{16'hFFFF, 12'hFFF};
        tbl[2] = '{16'h0000, 12'h000};
        tbl[3] = '{16'hF123, 12'h123};
        tbl[4] = '{16'h5A5A, 12'hA5A};
        tbl[5] = '{16'h8001, 12'h001};
        avg_w[0] = 16'h0100; avg_w[1] = 16'h0200; avg_w[2] = 16'h0300; avg_w[3] = 16'h0404;

        bus.start = 1'b0;
        rst_n = 1'b0;
        tick(3);
        check("rst cs_n", 32'(bus.cs_n), 32'd1);
        check("rst sck", 32'(bus.sck), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst valid", 32'(bus.sample_valid), 32'd0);
        check("rst data", 32'(bus.sample_data), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // back-to-back frames with start held high
        r0 = rises; b0 = bad_runs; f0 = cs_fall_q.size(); n = cs_rise_q.size();
        adc_words.push_back(16'hFFFF); model_frame(16'hFFFF);
        adc_words.push_back(16'h0000); model_frame(16'h0000);
        bus.start = 1'b1;
        d = 0;
        while (cs_rise_q.size() < n + 2 && d < 600) begin tick(1); d++; end
        bus.start = 1'b0;
        wait_done("b2b", n + 2);
        check("b2b frames", 32'(cs_fall_q.size() - f0), 32'd2);
        if (cs_fall_q.size() - f0 == 2)
            check("b2b quiet_len", 32'(cs_fall_q[f0+1] - cs_rise_q[n]), 32'(CSQ));
        score("b2b", r0, b0, 2 * FB);
        tick(3);

        // table-driven single frames
        for (int i = 0; i < 6; i++) begin
            r0 = rises; b0 = bad_runs;
            s = cyc;
            start_frame(tbl[i].word);
            wait_done($sformatf("tbl%0d", i), cs_rise_q.size() + 1);
            check($sformatf("tbl%0d start_to_cs", i), 32'(cs_fall_q[$] - s), 32'd4);
`ifndef ADC_AVG4_EN
            check($sformatf("tbl%0d n_valid", i), 32'(val_dat_q.size()), 32'd1);
            if (val_dat_q.size() > 0)
                check($sformatf("tbl%0d raw", i), 32'(val_dat_q[0]), 32'(tbl[i].raw));
`endif
            score($sformatf("tbl%0d", i), r0, b0, FB);
            tick(3);
        end

        // reset during sck pulse 7
        r0 = rises;
        start_frame(16'h0ABC);
        d = 0;
        while (rises - r0 < 7 && d < 300) begin tick(1); d++; end
        check("mid_rst reached_pulse7", 32'(d < 300), 32'd1);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst cs_n", 32'(bus.cs_n), 32'd1);
        check("mid_rst sck", 32'(bus.sck), 32'd0);
        check("mid_rst busy", 32'(bus.busy), 32'd0);
        check("mid_rst data", 32'(bus.sample_data), 32'd0);
        rst_n = 1'b1;
        model_reset();
        f0 = cs_fall_q.size();
        tick(160);
        check("mid_rst no_valid", 32'(val_dat_q.size()), 32'd0);
        check("mid_rst no_frame", 32'(cs_fall_q.size() - f0), 32'd0);
        check("mid_rst cs_idle", 32'(bus.cs_n), 32'd1);
        val_cyc_q.delete(); val_dat_q.delete();

        // four-frame group (averaged under ADC_AVG4_EN, raw otherwise)
        for (int i = 0; i < 4; i++) begin
            r0 = rises; b0 = bad_runs;
            start_frame(avg_w[i]);
            wait_done($sformatf("grp%0d", i), cs_rise_q.size() + 1);
`ifdef ADC_AVG4_EN
            check($sformatf("grp%0d n_valid", i), 32'(val_dat_q.size()), (i == 3) ? 32'd1 : 32'd0);
            if (i == 3 && val_dat_q.size() > 0)
                check("grp avg_data", 32'(val_dat_q[0]), 32'h281);
`endif
            score($sformatf("grp%0d", i), r0, b0, FB);
            tick(3);
        end

        // start dropped during bit 3: frame completes, no further frame
        r0 = rises; b0 = bad_runs; f0 = cs_fall_q.size();
        adc_words.push_back(16'h0C35); model_frame(16'h0C35);
        bus.start = 1'b1;
        d = 0;
        while (rises - r0 < 3 && d < 300) begin tick(1); d++; end
        bus.start = 1'b0;
        wait_done("drop", cs_rise_q.size() + 1);
        score("drop", r0, b0, FB);
        tick(60);
        check("drop one_frame", 32'(cs_fall_q.size() - f0), 32'd1);
        check("drop cs_idle", 32'(bus.cs_n), 32'd1);
        check("drop busy_idle", 32'(bus.busy), 32'd0);

        // random words, asynchronous 1-cycle start, miso glitches in low phases
        glitch_en = 1;
        for (int i = 0; i < 8; i++) begin
            w = 16'($urandom);
            r0 = rises; b0 = bad_runs;
            adc_words.push_back(w); model_frame(w);
            off = $urandom_range(1, 7);
            if (off >= 4) off++;          // keep clear of the negedge instant
            #(off);
            s = cyc;
            bus.start = 1'b1;
            #10;
            bus.start = 1'b0;
            wait_done($sformatf("rnd%0d", i), cs_rise_q.size() + 1);
            d = cs_fall_q[$] - s;
            check($sformatf("rnd%0d start_to_cs", i), 32'(d == 3 || d == 4), 32'd1);
            score($sformatf("rnd%0d", i), r0, b0, FB);
            tick(3);
        end
        glitch_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
